// File: rtl/alu_pkg.sv
// Opcode encodings and per-opcode flag-write rules shared by decode and the ALU result stage.
// Flag vectors are ordered {z, v, n} throughout.
package alu_pkg;

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_XOR    = 4'b0010;
    localparam logic [3:0] OP_RED    = 4'b0011;
    localparam logic [3:0] OP_SLL    = 4'b0100;
    localparam logic [3:0] OP_SRA    = 4'b0101;
    localparam logic [3:0] OP_ROR    = 4'b0110;
    localparam logic [3:0] OP_PADDSB = 4'b0111;

    localparam logic [2:0] FLG_ZVN  = 3'b111;
    localparam logic [2:0] FLG_Z    = 3'b100;
    localparam logic [2:0] FLG_NONE = 3'b000;

    // PADDSB saturates internally, so it must never touch V.
    function automatic logic [2:0] flag_mask(input logic [3:0] opcode);
        case (opcode)
            OP_ADD, OP_SUB:                 flag_mask = FLG_ZVN;
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: flag_mask = FLG_Z;
            default:                        flag_mask = FLG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/alu_flag_reg.sv
// Architectural Z/V/N flags with per-bit write enables; flag_upd pulses the cycle after any write.
// Latency 1 cycle from write enable to visible flag; no backpressure.
module alu_flag_reg (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] wr_en,
    input  logic [2:0] wr_val,
    output logic       flag_z,
    output logic       flag_v,
    output logic       flag_n,
    output logic       flag_upd
);

    always_ff @(posedge clk) begin
        if (rst) begin
            flag_z   <= 1'b0;
            flag_v   <= 1'b0;
            flag_n   <= 1'b0;
            flag_upd <= 1'b0;
        end else begin
            if (wr_en[2]) flag_z <= wr_val[2];
            if (wr_en[1]) flag_v <= wr_val[1];
            if (wr_en[0]) flag_n <= wr_val[0];
            flag_upd <= |wr_en;
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// Registers ALU results into a 2-entry skid buffer toward writeback and updates flags at accept time.
// Latency 1 cycle when empty; in_ready drops only when both head and skid are occupied.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int RD_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic [3:0]        in_opcode,
    input  logic              in_ovfl,
    input  logic [RD_W-1:0]   in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [RD_W-1:0]   out_rd,
    output logic              flag_z,
    output logic              flag_v,
    output logic              flag_n,
    output logic              flag_upd
);

    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b10;

    logic [1:0]        state;
    logic [DATA_W-1:0] head_result, skid_result;
    logic [RD_W-1:0]   head_rd, skid_rd;
    logic              accept, consume;
    logic [2:0]        flag_wen, flag_val;

    assign in_ready   = ~rst & (state != ST_FULL);
    assign out_valid  = (state != ST_EMPTY);
    assign out_result = head_result;
    assign out_rd     = head_rd;
    assign accept     = in_valid & in_ready;
    assign consume    = out_valid & out_ready;

    // An input offered during flush is squashed, including its flag effects.
    assign flag_wen = (accept & ~flush) ? flag_mask(in_opcode) : FLG_NONE;
    assign flag_val = {(in_result == '0), in_ovfl, in_result[DATA_W-1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_EMPTY;
            head_result <= '0;
            head_rd     <= '0;
            skid_result <= '0;
            skid_rd     <= '0;
        end else if (flush) begin
            state <= ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        head_result <= in_result;
                        head_rd     <= in_rd;
                        state       <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && consume) begin
                        head_result <= in_result;
                        head_rd     <= in_rd;
                    end else if (accept) begin
                        skid_result <= in_result;
                        skid_rd     <= in_rd;
                        state       <= ST_FULL;
                    end else if (consume) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (consume) begin
                        head_result <= skid_result;
                        head_rd     <= skid_rd;
                        state       <= ST_ONE;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

    alu_flag_reg u_flag_reg (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (flag_wen),
        .wr_val   (flag_val),
        .flag_z   (flag_z),
        .flag_v   (flag_v),
        .flag_n   (flag_n),
        .flag_upd (flag_upd)
    );

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: stimulus pushes expected entries, a negedge monitor pops and compares.
module tb_alu_result_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_result = '0;
    logic [3:0]  in_opcode = '0;
    logic        in_ovfl = 1'b0;
    logic [3:0]  in_rd = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_result;
    logic [3:0]  out_rd;
    logic        flag_z, flag_v, flag_n, flag_upd;

    alu_result_stage #(.DATA_W(16), .RD_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_opcode(in_opcode), .in_ovfl(in_ovfl), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd),
        .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n), .flag_upd(flag_upd)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: entries held inside the stage, oldest first, as {rd, result}.
    logic [19:0] q[$];
    logic        mz = 1'b0, mv = 1'b0, mn = 1'b0, mupd = 1'b0;
    logic        ready_snap = 1'b0;
    logic        acc_last = 1'b0;
    logic        started = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at time %0t", nm, act, exp, $time);
        end
    endtask

    // Model update at the clock edge, from the inputs the DUT is also sampling.
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            {mz, mv, mn, mupd} = 4'b0000;
            acc_last = 1'b0;
        end else if (flush) begin
            q.delete();
            mupd = 1'b0;
            acc_last = 1'b0;
        end else begin
            acc_last = in_valid && ready_snap;
            mupd = 1'b0;
            if (acc_last) begin
                q.push_back({in_rd, in_result});
                if (in_opcode == 4'd0 || in_opcode == 4'd1) begin
                    mz = (in_result == 16'd0);
                    mv = in_ovfl;
                    mn = in_result[15];
                    mupd = 1'b1;
                end else if (in_opcode == 4'd2 || in_opcode == 4'd4 ||
                             in_opcode == 4'd5 || in_opcode == 4'd6) begin
                    mz = (in_result == 16'd0);
                    mupd = 1'b1;
                end
            end
        end
        started = 1'b1;
    end

    // Monitor: compares every cycle and retires the head whenever writeback takes it.
    always @(negedge clk) begin
        if (started) begin
            ready_snap = !rst && (q.size() < 2);
            check("in_ready", {31'd0, in_ready}, {31'd0, ready_snap});
            check("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
            if (q.size() != 0) begin
                check("out_result", {16'd0, out_result}, {16'd0, q[0][15:0]});
                check("out_rd", {28'd0, out_rd}, {28'd0, q[0][19:16]});
            end
            check("flags_zvn", {29'd0, flag_z, flag_v, flag_n}, {29'd0, mz, mv, mn});
            check("flag_upd", {31'd0, flag_upd}, {31'd0, mupd});
            if (q.size() != 0 && out_ready) void'(q.pop_front());
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [3:0] op, input logic [15:0] r, input logic ov, input logic [3:0] rd);
        in_valid = 1'b1; in_opcode = op; in_result = r; in_ovfl = ov; in_rd = rd;
    endtask

    // Offer one result and hold it until accepted, bounded.
    task automatic send(input logic [3:0] op, input logic [15:0] r, input logic ov, input logic [3:0] rd);
        int k;
        offer(op, r, ov, rd);
        k = 0;
        do begin
            cycle();
            k++;
        end while (!acc_last && k < 20);
        n_vec++;
        if (!acc_last) begin
            n_err++;
            $display("FAIL send_timeout: got no accept, expected accept within 20 cycles");
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        repeat (4) cycle();
        out_ready = 1'b0;
    endtask

    logic [2:0] saved;

    initial begin
        // Reset held with a valid input presented.
        rst = 1'b1;
        offer(4'd0, 16'h1234, 1'b1, 4'd1);
        cycle();
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        cycle();
        check("rst_flags", {29'd0, flag_z, flag_v, flag_n}, 32'd0);
        check("rst_out_result", {16'd0, out_result}, 32'd0);
        check("rst_out_rd", {28'd0, out_rd}, 32'd0);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // ADD of zero with overflow, then XOR writes Z only.
        send(4'b0000, 16'h0000, 1'b1, 4'd3);
        check("add_flags", {29'd0, flag_z, flag_v, flag_n}, 32'b110);
        check("add_upd", {31'd0, flag_upd}, 32'd1);
        cycle();
        check("add_upd_pulse", {31'd0, flag_upd}, 32'd0);
        send(4'b0010, 16'h8000, 1'b0, 4'd4);
        check("xor_flags", {29'd0, flag_z, flag_v, flag_n}, 32'b010);
        drain();

        // PADDSB leaves flags alone even with overflow asserted.
        send(4'b0111, 16'h7878, 1'b1, 4'd9);
        check("paddsb_flags", {29'd0, flag_z, flag_v, flag_n}, 32'b010);
        check("paddsb_upd", {31'd0, flag_upd}, 32'd0);
        check("paddsb_result", {16'd0, out_result}, 32'h7878);
        check("paddsb_rd", {28'd0, out_rd}, 32'd9);
        drain();

        // Back-pressure: A and B fill the buffer, C is held off until release.
        send(4'd3, 16'hAAAA, 1'b0, 4'd10);
        send(4'd3, 16'hBBBB, 1'b0, 4'd11);
        check("bp_full_ready", {31'd0, in_ready}, 32'd0);
        offer(4'd3, 16'hCCCC, 1'b0, 4'd12);
        repeat (3) begin
            cycle();
            check("bp_c_held", {31'd0, acc_last}, 32'd0);
        end
        out_ready = 1'b1;
        send(4'd3, 16'hCCCC, 1'b0, 4'd12);
        drain();

        // Streaming: simultaneous accept and consume never bubbles.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            offer(4'($urandom_range(0, 15)), 16'($urandom), 1'($urandom), 4'($urandom));
            cycle();
            check("stream_valid", {31'd0, out_valid}, 32'd1);
            check("stream_accept", {31'd0, acc_last}, 32'd1);
        end
        in_valid = 1'b0;
        drain();

        // Flush from FULL with a SUB offered.
        send(4'd0, 16'h8001, 1'b0, 4'd1);
        send(4'd3, 16'h0001, 1'b0, 4'd2);
        saved = {flag_z, flag_v, flag_n};
        offer(4'b0001, 16'h0000, 1'b1, 4'd5);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_full_valid", {31'd0, out_valid}, 32'd0);
        check("flush_full_flags", {29'd0, flag_z, flag_v, flag_n}, {29'd0, saved});
        check("flush_full_ready", {31'd0, in_ready}, 32'd1);

        // Flush from ONE, where the SUB would otherwise be accepted.
        send(4'd3, 16'h4444, 1'b0, 4'd6);
        saved = {flag_z, flag_v, flag_n};
        offer(4'b0001, 16'h0000, 1'b1, 4'd7);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_one_valid", {31'd0, out_valid}, 32'd0);
        check("flush_one_flags", {29'd0, flag_z, flag_v, flag_n}, {29'd0, saved});
        check("flush_one_upd", {31'd0, flag_upd}, 32'd0);

        // Reset mid-transfer discards entries and clears flags.
        send(4'd0, 16'h0000, 1'b1, 4'd8);
        send(4'd3, 16'h1111, 1'b0, 4'd9);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_flags", {29'd0, flag_z, flag_v, flag_n}, 32'd0);
        check("midrst_result", {16'd0, out_result}, 32'd0);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            flush = ($urandom_range(0, 19) == 0);
            out_ready = flush ? 1'b0 : 1'($urandom);
            in_valid = 1'($urandom);
            in_opcode = 4'($urandom_range(0, 15));
            in_result = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
            in_ovfl = 1'($urandom);
            in_rd = 4'($urandom);
            cycle();
        end
        flush = 1'b0;
        in_valid = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered stage directly downstream of the ALU, including the 16-bit saturating PADDSB adder.
- Captures each ALU result with its destination register and opcode, and maintains the architectural Z/V/N flag register according to per-opcode update rules.
- Buffers results in a 2-entry skid buffer toward writeback, using a valid/ready handshake on both sides so writeback back-pressure never drops an ALU result.

Parameters:
- DATA_W, 16, result width (PADDSB lane boundaries are every 4 bits; this stage does not inspect lanes)
- RD_W, 4, destination register index width

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- flush  input  1  synchronous squash of all buffered entries (taken branch)
- in_valid  input  1  ALU result present
- in_ready  output  1  stage can accept this cycle
- in_result  input  DATA_W  ALU result (already saturated for PADDSB)
- in_opcode  input  4  opcode of producing instruction
- in_ovfl  input  1  signed overflow of ADD/SUB (ignored for other opcodes)
- in_rd  input  RD_W  destination register
- out_valid  output  1  entry available to writeback
- out_ready  input  1  writeback consumes this cycle
- out_result  output  DATA_W  buffered result
- out_rd  output  RD_W  buffered destination
- flag_z, flag_v, flag_n  output  1 each  architectural flags
- flag_upd  output  1  one-cycle pulse, asserted the cycle after any flag bit was written

Behaviour:
- Accept = in_valid & in_ready. Consume = out_valid & out_ready.
- in_ready is combinational from state: 1 in EMPTY and ONE, 0 in FULL, and forced 0 while rst = 1.
- State machine, with one head register (drives the out_* ports) and one skid register:
  - EMPTY: on accept, load head and go to ONE.
  - ONE, accept & consume: head <= input; stay in ONE.
  - ONE, accept & ~consume: skid <= input; go to FULL.
  - ONE, ~accept & consume: go to EMPTY.
  - FULL, consume: head <= skid; go to ONE. Accept is impossible because in_ready = 0.
  - FULL, ~consume: hold.
- out_valid = (state != EMPTY).
- Order is strictly FIFO. Head output data is stable while out_valid & ~out_ready.
- Latency is 1 cycle from accept to out_valid when the stage is empty.
- Flag update occurs at accept time, in program order, not at writeback. Flags are visible on the flag outputs the cycle after accept.
  - Z = (in_result == 0). N = in_result[15]. V = in_ovfl.
  - ADD 0000, SUB 0001: write Z, V and N.
  - XOR 0010, SLL 0100, SRA 0101, ROR 0110: write Z only.
  - RED 0011, PADDSB 0111, and all other opcodes: write no flags. A saturated PADDSB result never sets V.
  - flag_upd is asserted the cycle after accept of any flag-writing opcode.
- flush has priority over accept and consume:
  - Next state is EMPTY and out_valid is 0 next cycle.
  - An input presented in the flush cycle is discarded and does not update flags.
  - Flags written by earlier accepts are not rolled back.
- rst has priority over flush. All outputs clear:
  - state EMPTY, out_valid 0, out_result 0, out_rd 0;
  - flag_z/v/n 0, flag_upd 0.
  - Reset mid-transfer discards buffered entries.
- Simultaneous consume of the head and accept in state ONE must not create a bubble. out_valid stays 1 with the new data.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams (OP_ADD … OP_PADDSB);
  - flag-write masks FLG_ZVN, FLG_Z, FLG_NONE;
  - a function flag_mask(opcode), reused by the decode stage.
- One sub-module: alu_flag_reg (3-bit flag register with per-bit write enables plus the flag_upd pulse). The skid buffer stays inline.

Test Plan:
- Reset: hold rst for 2 cycles with in_valid = 1 → in_ready = 0, out_valid = 0, flags 000; in_ready = 1 in the first cycle after release.
- ADD flag update: accept ADD result 0x0000 with in_ovfl = 1 → Z = 1, V = 1, N = 0 next cycle, flag_upd pulses once; then XOR 0x8000 → Z = 0, V = 1 and N = 0 retained.
- PADDSB: accept PADDSB result 0x7878 (saturated lanes) with in_ovfl = 1 → flags unchanged, flag_upd = 0; out_result = 0x7878 and out_rd matches the input.
- Back-pressure: out_ready = 0, accept 3 results A, B, C → in_ready drops after B and C is held off; release out_ready → outputs A, B, C in order with no loss or duplication.
- Streaming: out_ready = 1 with in_valid = 1 continuously for 8 cycles → 8 consecutive outputs, out_valid never drops after the first.
- Flush: FULL state plus flush with in_valid = 1 carrying SUB → out_valid = 0 next cycle, flags unchanged by the SUB, in_ready = 1.
